// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int N_WORDS_DEF    = 64;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    FILL,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and RAM write port of the loader, bundled as one interface.
interface imem_loader_if #(
  parameter int AW = 6,
  parameter int DW = 32
) ();

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  // master is the loader's view; slave is the byte source plus RAM side
  modport master (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs stream bytes MSB first into one instruction word; flags the final byte.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          shift_en,
  input  logic                          clear,
  input  logic [7:0]                    byte_in,
  output logic [BYTES_PER_WORD*8-1:0]   word,
  output logic                          word_full
);

  logic [1:0]                  cnt_q, cnt_d;
  logic [BYTES_PER_WORD*8-1:0] word_q, word_d;

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear) begin
      cnt_d = '0;
    end else if (shift_en) begin
      word_d = {word_q[BYTES_PER_WORD*8-9:0], byte_in};
      cnt_d  = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word      = word_q;
  assign word_full = shift_en && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into the instruction RAM, zero-fills the
// remainder and holds the CPU until the image is complete.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int N_WORDS = N_WORDS_DEF,
  parameter int AW      = 6,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic          cpu_hold
);

  localparam logic [7:0] MAX_LEN   = 8'(N_WORDS);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(N_WORDS);
  localparam logic [AW:0] CNT_LAST = (AW+1)'(N_WORDS - 1);

  state_e        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   cnt_inc;
  logic          accept;
  logic          xfer;
  logic          word_full;
  logic [DW-1:0] word;

  assign accept  = (state_q == LEN) || (state_q == DATA);
  assign xfer    = accept && bus.byte_valid;
  assign cnt_inc = cnt_q + 1'b1;

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (xfer && (state_q == DATA)),
    .clear     (state_q == WRITE),
    .byte_in   (bus.byte_data),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    unique case (state_q)
      IDLE, DONE, ERR: if (start) state_d = LEN;
      LEN: begin
        if (xfer) begin
          if ((bus.byte_data == 8'd0) || (bus.byte_data > MAX_LEN)) begin
            state_d = ERR;
          end else begin
            len_d   = (AW+1)'(bus.byte_data);
            cnt_d   = '0;
            state_d = DATA;
          end
        end
      end
      DATA: if (word_full) state_d = WRITE;
      WRITE: begin
        cnt_d = cnt_inc;
        if (cnt_inc == len_q) state_d = (len_q < CNT_FULL) ? FILL : DONE;
        else                  state_d = DATA;
      end
      // The counter stops advancing once DONE is reached, so addresses never wrap
      FILL: begin
        cnt_d = cnt_inc;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state_q == LEN) || (state_q == DATA) ||
                     (state_q == WRITE) || (state_q == FILL);
    done           = (state_q == DONE);
    error          = (state_q == ERR);
    cpu_hold       = (state_q != DONE);
    bus.byte_ready = accept;
    bus.mem_we     = (state_q == WRITE) || (state_q == FILL);
    bus.mem_addr   = bus.mem_we ? cnt_q[AW-1:0] : '0;
    bus.mem_wdata  = (state_q == WRITE) ? word : '0;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a behavioural model of the instruction RAM.
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic busy, done, error, cpu_hold;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  int dt    = 0;
  int we0, z0, s0;

  always #5 clk = ~clk;

  imem_loader_if #(.AW(6), .DW(32)) bus ();

  imem_loader #(.N_WORDS(64), .AW(6), .DW(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .cpu_hold (cpu_hold)
  );

  // RAM model plus write-sequence bookkeeping
  logic [31:0] ram [64];
  int          we_cnt    = 0;
  int          zero_cnt  = 0;
  int          seq_err   = 0;
  logic [5:0]  last_addr = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_we === 1'b1) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
      we_cnt <= we_cnt + 1;
      if (bus.mem_addr == 6'd0) zero_cnt <= zero_cnt + 1;
      else if (bus.mem_addr != last_addr + 6'd1) seq_err <= seq_err + 1;
      last_addr <= bus.mem_addr;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {bus.mem_we, busy, done, error, cpu_hold, bus.byte_ready, bus.mem_addr, bus.mem_wdata},
          {6'b000010, 6'd0, 32'd0});
  endtask

  task automatic begin_load();
    we0 = we_cnt;
    z0  = zero_cnt;
    s0  = seq_err;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    rdy = 1'b0;
    repeat (gap) begin
      bus.byte_valid = 1'b0;
      @(negedge clk);
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int i = 0; i < 50; i++) begin
      rdy = bus.byte_ready;
      @(negedge clk);
      if (rdy) break;
    end
    bus.byte_valid = 1'b0;
    if (!rdy) check("byte_accept", rdy, 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit bp);
    logic [31:0] tmp;
    tmp = w;
    for (int k = 0; k < 4; k++) begin
      send_byte(tmp[31:24], bp ? int'($urandom_range(0, 2)) : 0);
      tmp = tmp << 8;
    end
  endtask

  task automatic wait_end();
    for (int i = 0; i < 2000; i++) begin
      if (done || error) break;
      @(negedge clk);
    end
    dt = cyc - t0;
    check("end_reached", done | error, 1'b1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int diffs;
    logic [31:0] exp_img [64];
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_outputs");
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle_outputs");

    // Full image: 64 words, no fill
    begin_load();
    pulse_start();
    check("len_busy_hold_ready", {busy, cpu_hold, bus.byte_ready}, 3'b111);
    send_byte(8'h40, 0);
    for (int i = 0; i < 64; i++) send_word({8'hA5, 8'(i), 8'h5A, ~8'(i)}, 1'b0);
    wait_end();
    check("full_done", {done, busy, cpu_hold}, 3'b100);
    check("full_cycles", dt, 321);
    check("full_we_count", we_cnt - we0, 64);
    check("full_addr0_writes", zero_cnt - z0, 1);
    check("full_seq", seq_err - s0, 0);
    check("full_last_addr", last_addr, 6'd63);
    check("full_ram0", ram[0], 32'ha5005aff);
    check("full_ram48", ram[48], 32'ha5305acf);
    check("full_ram63", ram[63], 32'ha53f5ac0);

    // Two-word load with zero-fill
    begin_load();
    pulse_start();
    send_byte(8'h02, 0);
    send_word(32'hf8000001, 1'b0);
    send_word(32'hf8008002, 1'b0);
    wait_end();
    check("two_cycles", dt, 73);
    check("two_done", {done, busy, cpu_hold}, 3'b100);
    check("two_ram0", ram[0], 32'hf8000001);
    check("two_ram1", ram[1], 32'hf8008002);
    check("two_ram47", ram[47], 32'h0);
    check("two_ram48", ram[48], 32'h0);
    check("two_ram49", ram[49], 32'h0);
    check("two_we_count", we_cnt - we0, 64);
    check("two_seq", seq_err - s0, 0);
    repeat (5) @(negedge clk);
    check("two_done_held", {done, cpu_hold, bus.mem_we}, 3'b100);

    // Bad length 0, then 65, then a good retry
    begin_load();
    pulse_start();
    send_byte(8'h00, 0);
    check("len0_err", {error, busy, cpu_hold, done, bus.byte_ready}, 5'b10100);
    pulse_start();
    check("retry_clears_err", {error, busy}, 2'b01);
    send_byte(8'h41, 0);
    check("len65_err", {error, busy, cpu_hold}, 3'b101);
    check("err_no_writes", we_cnt - we0, 0);
    begin_load();
    pulse_start();
    send_byte(8'h01, 0);
    send_word(32'h12345678, 1'b0);
    wait_end();
    check("retry_done", {done, error}, 2'b10);
    check("retry_ram0", ram[0], 32'h12345678);
    check("retry_ram1", ram[1], 32'h0);
    check("retry_we_count", we_cnt - we0, 64);

    // Backpressure on a 3-word load
    begin_load();
    pulse_start();
    send_byte(8'h03, 2);
    send_word(32'h01020304, 1'b1);
    send_word(32'ha0b0c0d0, 1'b1);
    send_word(32'hdeadbeef, 1'b1);
    wait_end();
    for (int i = 0; i < 64; i++) exp_img[i] = 32'h0;
    exp_img[0] = 32'h01020304;
    exp_img[1] = 32'ha0b0c0d0;
    exp_img[2] = 32'hdeadbeef;
    diffs = 0;
    for (int i = 0; i < 64; i++) if (ram[i] !== exp_img[i]) diffs++;
    check("bp_done", done, 1'b1);
    check("bp_image_diffs", diffs, 0);
    check("bp_we_count", we_cnt - we0, 64);

    // Reset in the middle of the first word
    begin_load();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'haa, 0);
    send_byte(8'hbb, 0);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mid_outputs");
    reset = 1'b1;
    check("rst_mid_no_writes", we_cnt - we0, 0);
    begin_load();
    pulse_start();
    send_byte(8'h01, 0);
    send_word(32'h0badcafe, 1'b0);
    wait_end();
    check("rst_reload_cycles", dt, 69);
    check("rst_reload_ram0", ram[0], 32'h0badcafe);
    check("rst_reload_addr0", zero_cnt - z0, 1);
    check("rst_reload_we", we_cnt - we0, 64);

    // start during DATA is ignored; start in DONE reloads
    begin_load();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mid_start_ignored", {busy, done, bus.byte_ready}, 3'b101);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_word(32'h55667788, 1'b0);
    wait_end();
    check("mid_start_cycles", dt, 74);
    check("mid_start_ram0", ram[0], 32'h11223344);
    check("mid_start_ram1", ram[1], 32'h55667788);
    check("mid_start_ram2", ram[2], 32'h0);
    begin_load();
    pulse_start();
    check("reload_flags", {busy, cpu_hold, done}, 3'b110);
    send_byte(8'h01, 0);
    send_word(32'hfeedf00d, 1'b0);
    wait_end();
    check("reload_ram0", ram[0], 32'hfeedf00d);
    check("reload_ram1", ram[1], 32'h0);
    check("reload_we", we_cnt - we0, 64);
    check("reload_seq", seq_err - s0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
